// File: rtl/digit_display_pkg.sv
// Shared constants for the scanned 8-digit display: geometry and the
// active-low {g,f,e,d,c,b,a} segment patterns.
package digit_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned WINDOW_W   = NUM_DIGITS * DIGIT_W;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned SCAN_CNT_W = 16;
  localparam int unsigned COUNT_W    = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder; non-decimal
// values and unfilled positions render blank.
module seg7_decode
  import digit_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/digit_display.sv
// Shifts incoming digits into an 8-digit window, scans the window onto a
// multiplexed display, and flags/counts occurrences of a fixed pattern.
module digit_display
  import digit_display_pkg::*;
#(
  parameter int unsigned          SCAN_DIV = 4,
  parameter logic [WINDOW_W-1:0]  PATTERN  = 32'h0085_7005
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGIT_W-1:0]    digit_in,
  input  logic                  digit_valid,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  match,
  output logic [COUNT_W-1:0]    match_count
);

  localparam logic [SCAN_CNT_W-1:0] SCAN_LAST  = SCAN_CNT_W'(SCAN_DIV - 1);
  localparam logic [COUNT_W-1:0]    COUNT_MAX  = '1;

  logic [WINDOW_W-1:0]   window;
  logic [WINDOW_W-1:0]   window_next_c;
  logic [NUM_DIGITS-1:0] filled;
  logic [NUM_DIGITS-1:0] filled_next_c;
  logic [SCAN_CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [DIGIT_W-1:0]    cur_digit_c;
  logic                  cur_filled_c;
  logic [SEG_W-1:0]      seg_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic                  hit_c;

  // Next window contents and the digit currently selected by the scan.
  always_comb begin
    window_next_c = {window[WINDOW_W-DIGIT_W-1:0], digit_in};
    filled_next_c = {filled[NUM_DIGITS-2:0], 1'b1};
    hit_c         = (&filled_next_c) && (window_next_c == PATTERN);
    cur_digit_c   = window[scan_idx*DIGIT_W +: DIGIT_W];
    cur_filled_c  = filled[scan_idx];
    an_c          = ~(NUM_DIGITS'(1) << scan_idx);
  end

  seg7_decode u_seg7_decode (
    .digit (cur_digit_c),
    .blank (!cur_filled_c),
    .seg_c (seg_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      window      <= '0;
      filled      <= '0;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      match       <= 1'b0;
      match_count <= '0;
      seg         <= SEG_BLANK;
      an          <= '1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_CNT_W'(1);
      end

      seg <= seg_c;
      an  <= an_c;

      // match only changes on a strobe, so it holds between digits.
      if (digit_valid) begin
        window <= window_next_c;
        filled <= filled_next_c;
        match  <= hit_c;
        if (hit_c && (match_count != COUNT_MAX)) begin
          match_count <= match_count + COUNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_display.sv
// Scoreboard bench for digit_display: a driver predicts match/match_count per
// strobe, a monitor checks those plus the scanned seg/an every cycle.
module tb_digit_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam logic [31:0] PATTERN  = 32'h0085_7005;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic [6:0] seg;
  logic [7:0] an;
  logic       match;
  logic [7:0] match_count;

  digit_display #(
    .SCAN_DIV (SCAN_DIV),
    .PATTERN  (PATTERN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .seg         (seg),
    .an          (an),
    .match       (match),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       m;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pattern_digit(input int i);
    return int'((PATTERN >> (4 * (7 - i))) & 32'hF);
  endfunction

  function automatic logic [6:0] ref_seg(input int d, input bit present);
    if (!present) return 7'b1111111;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Driver-side reference: last eight accepted digits and the saturating count.
  int drv_hist[$];
  int drv_count = 0;

  function automatic bit window_is_pattern();
    if (drv_hist.size() < 8) return 1'b0;
    for (int i = 0; i < 8; i++)
      if (drv_hist[i] != pattern_digit(i)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic strobe(input int d, input int period);
    exp_t e;
    digit_in    = 4'(d);
    digit_valid = 1'b1;
    drv_hist.push_back(d);
    if (drv_hist.size() > 8) void'(drv_hist.pop_front());
    e.m = window_is_pattern();
    if (e.m && drv_count < 255) drv_count++;
    e.cnt = 8'(drv_count);
    exp_q.push_back(e);
    @(negedge clk);
    digit_valid = 1'b0;
    digit_in    = 4'($urandom);
    repeat (period - 1) @(negedge clk);
  endtask

  task automatic apply_reset(input int cycles);
    reset       = 1'b1;
    digit_valid = 1'b0;
    drv_hist.delete();
    drv_count = 0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_pattern(input int period);
    for (int i = 0; i < 8; i++) strobe(pattern_digit(i), period);
  endtask

  // Monitor: scan position derived from cycles since reset release.
  initial begin
    int   t;
    int   idx;
    bit   active;
    logic exp_m;
    logic [7:0] exp_cnt;
    logic [7:0] exp_an;
    int   mon_hist[$];
    exp_t e;
    t = 0; active = 1'b0; exp_m = 1'b0; exp_cnt = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("reset_an", 32'(an), 32'hFF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_match", 32'(match), 32'd0);
        check("reset_count", 32'(match_count), 32'd0);
        t = 0; active = 1'b1; exp_m = 1'b0; exp_cnt = 8'd0;
        mon_hist.delete();
      end else if (active) begin
        idx    = (t / int'(SCAN_DIV)) % 8;
        exp_an = ~(8'(1) << idx);
        check("scan_an", 32'(an), 32'(exp_an));
        if (idx < mon_hist.size())
          check("scan_seg", 32'(seg), 32'(ref_seg(mon_hist[mon_hist.size() - 1 - idx], 1'b1)));
        else
          check("scan_seg", 32'(seg), 32'(ref_seg(0, 1'b0)));
        t++;
        if (digit_valid) begin
          mon_hist.push_back(int'(digit_in));
          if (mon_hist.size() > 8) void'(mon_hist.pop_front());
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: strobe seen with no expected entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            exp_m   = e.m;
            exp_cnt = e.cnt;
          end
        end
        check("match", 32'(match), 32'(exp_m));
        check("match_count", 32'(match_count), 32'(exp_cnt));
      end
    end
  end

  initial begin
    int p;
    int d;
    @(negedge clk);

    // Reset then idle scan
    apply_reset(3);
    repeat (40) @(negedge clk);

    // Single pattern at 8-cycle spacing
    apply_reset(2);
    send_pattern(8);
    check("seq_match", 32'(match), 32'd1);
    check("seq_count", 32'(match_count), 32'd1);

    // 40 back-to-back periods
    apply_reset(2);
    repeat (40) send_pattern(8);
    check("cont_count", 32'(match_count), 32'd40);

    // Saturation
    apply_reset(2);
    for (int n = 0; n < 300; n++)
      for (int i = 0; i < 8; i++) strobe(pattern_digit(i), int'($urandom_range(1, 3)));
    check("sat_count", 32'(match_count), 32'd255);

    // Invalid digit, then pattern-biased random digits
    apply_reset(2);
    send_pattern(2);
    strobe(4'hC, 40);
    send_pattern(3);
    check("inv_count", 32'(match_count), 32'd2);
    p = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(9) < 8) begin
        d = pattern_digit(p);
        p = (p + 1) % 8;
      end else begin
        d = int'($urandom_range(15));
        p = 0;
      end
      strobe(d, int'($urandom_range(1, 4)));
    end

    // Reset colliding with a strobe mid-window
    apply_reset(2);
    for (int i = 0; i < 4; i++) strobe(pattern_digit(i), 2);
    reset       = 1'b1;
    digit_valid = 1'b1;
    digit_in    = 4'(pattern_digit(0));
    drv_hist.delete();
    drv_count = 0;
    @(negedge clk);
    digit_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i < 8; i++) strobe(pattern_digit(i), 5);
    check("coll_match", 32'(match), 32'd0);
    check("coll_count", 32'(match_count), 32'd0);
    repeat (40) @(negedge clk);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
